gat_bram_loader: RTL and testbench



---
 rtl/gat_pkg.sv | 9 +
 rtl/gat_bram_wr_port.sv | 30 +++
 rtl/gat_bram_loader.sv | 122 ++++++++++++
 tb/tb_gat_bram_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// gat_pkg: shared target encoding, header field positions and loader FSM states
package gat_pkg;
    typedef enum logic [1:0] {TGT_H_DATA, TGT_NODE_INFO, TGT_WGT, TGT_RSVD} tgt_e;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;
    localparam int HDR_TGT_LSB = 0;
    localparam int HDR_TGT_MSB = 1;
    localparam int HDR_N_LSB = 8;
    localparam int HDR_N_MSB = 31;
endpackage

// File: rtl/gat_bram_wr_port.sv
// gat_bram_wr_port: registered ena/wea/din/addra driver for one BRAM write port
module gat_bram_wr_port #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [31:0]       data,
    input  logic [ADDR_W-1:0] idx,
    output logic              ena,
    output logic              wea,
    output logic [31:0]       din,
    output logic [ADDR_W+1:0] addra
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ena <= 1'b0;
            wea <= 1'b0;
            din <= '0;
            addra <= '0;
        end else begin
            ena <= we;
            wea <= we;
            if (we) begin
                din <= data;
                addra <= {idx, 2'b00};
            end
        end
    end
endmodule

// File: rtl/gat_bram_loader.sv
// gat_bram_loader: framed 32-bit stream to H-data / node-info / weight BRAM writes.
// GAT_LOADER_CHECK_EN enables header checks, the DRAIN path and loader_err.
module gat_bram_loader
    import gat_pkg::*;
#(
    parameter int H_DATA_DEPTH = 242101,
    parameter int NODE_INFO_DEPTH = 13264,
    parameter int WEIGHT_DEPTH = 22928,
    parameter int H_DATA_ADDR_W = $clog2(H_DATA_DEPTH),
    parameter int NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH),
    parameter int WEIGHT_ADDR_W = $clog2(WEIGHT_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        load_clr,
    output logic [31:0]                 h_data_bram_din,
    output logic                        h_data_bram_ena,
    output logic                        h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
    output logic [31:0]                 h_node_info_bram_din,
    output logic                        h_node_info_bram_ena,
    output logic                        h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
    output logic [31:0]                 wgt_bram_din,
    output logic                        wgt_bram_ena,
    output logic                        wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
    output logic                        h_data_bram_load_done,
    output logic                        h_node_info_bram_load_done,
    output logic                        wgt_bram_load_done,
    output logic                        loader_busy,
    output logic                        loader_err
);
    state_e state, nxt, idle_nxt;
    tgt_e tgt_r, hdr_tgt, tgt_sel;
    logic [23:0] hdr_n, len, cnt;
    logic hs, last, in_done;
    assign hdr_tgt = tgt_e'(s_data[HDR_TGT_MSB:HDR_TGT_LSB]);
    assign hdr_n = s_data[HDR_N_MSB:HDR_N_LSB];
    assign hs = s_valid & s_ready;
    assign last = cnt == len - 24'd1;
    assign in_done = state == DONE;
`ifdef GAT_LOADER_CHECK_EN
    logic bad_hdr;
    logic [23:0] depth;
    always_comb begin
        depth = hdr_tgt == TGT_H_DATA ? 24'(H_DATA_DEPTH) :
                hdr_tgt == TGT_NODE_INFO ? 24'(NODE_INFO_DEPTH) : 24'(WEIGHT_DEPTH);
        bad_hdr = hdr_tgt == TGT_RSVD || hdr_n > depth;
        idle_nxt = hdr_n == 24'd0 ? IDLE : bad_hdr ? DRAIN : LOAD;
        tgt_sel = hdr_tgt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) loader_err <= 1'b0;
        else if (state == IDLE && hs && (hdr_n == 24'd0 || bad_hdr)) loader_err <= 1'b1;
    end
`else
    // Unchecked build: empty frames complete immediately, reserved target aliases weight
    always_comb begin
        idle_nxt = hdr_n == 24'd0 ? DONE : LOAD;
        tgt_sel = hdr_tgt == TGT_RSVD ? TGT_WGT : hdr_tgt;
    end
    assign loader_err = 1'b0;
`endif
    always_comb begin
        nxt = state == IDLE ? (hs ? idle_nxt : IDLE) :
              state == LOAD ? (hs && last ? DONE : LOAD) :
              state == DRAIN ? (hs && last ? IDLE : DRAIN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            s_ready <= 1'b1;
            loader_busy <= 1'b0;
            tgt_r <= TGT_H_DATA;
            len <= '0;
            cnt <= '0;
            h_data_bram_load_done <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done <= 1'b0;
        end else begin
            state <= nxt;
            s_ready <= nxt != DONE;
            loader_busy <= nxt != IDLE;
            if (state == IDLE && hs) begin
                tgt_r <= tgt_sel;
                len <= hdr_n;
                cnt <= '0;
            end else if (hs) begin
                cnt <= cnt + 24'd1;
            end
            // A set in the DONE cycle takes priority over a simultaneous clear
            h_data_bram_load_done <= (in_done && tgt_r == TGT_H_DATA) || (h_data_bram_load_done && !load_clr);
            h_node_info_bram_load_done <= (in_done && tgt_r == TGT_NODE_INFO) || (h_node_info_bram_load_done && !load_clr);
            wgt_bram_load_done <= (in_done && tgt_r == TGT_WGT) || (wgt_bram_load_done && !load_clr);
        end
    end
    gat_bram_wr_port #(.ADDR_W(H_DATA_ADDR_W)) u_h_data (
        .clk(clk), .rst_n(rst_n),
        .we(hs && state == LOAD && tgt_r == TGT_H_DATA),
        .data(s_data), .idx(cnt[H_DATA_ADDR_W-1:0]),
        .ena(h_data_bram_ena), .wea(h_data_bram_wea),
        .din(h_data_bram_din), .addra(h_data_bram_addra)
    );
    gat_bram_wr_port #(.ADDR_W(NODE_INFO_ADDR_W)) u_node_info (
        .clk(clk), .rst_n(rst_n),
        .we(hs && state == LOAD && tgt_r == TGT_NODE_INFO),
        .data(s_data), .idx(cnt[NODE_INFO_ADDR_W-1:0]),
        .ena(h_node_info_bram_ena), .wea(h_node_info_bram_wea),
        .din(h_node_info_bram_din), .addra(h_node_info_bram_addra)
    );
    gat_bram_wr_port #(.ADDR_W(WEIGHT_ADDR_W)) u_wgt (
        .clk(clk), .rst_n(rst_n),
        .we(hs && state == LOAD && tgt_r == TGT_WGT),
        .data(s_data), .idx(cnt[WEIGHT_ADDR_W-1:0]),
        .ena(wgt_bram_ena), .wea(wgt_bram_wea),
        .din(wgt_bram_din), .addra(wgt_bram_addra)
    );
endmodule

// File: tb/tb_gat_bram_loader.sv
// tb_gat_bram_loader: directed self-checking bench for gat_bram_loader.
// H-data depth is reduced to 1000 so the oversize-drain frame stays short.
module tb_gat_bram_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic load_clr = 1'b0;
    logic [31:0] hd_din, ni_din, w_din;
    logic hd_ena, hd_wea, ni_ena, ni_wea, w_ena, w_wea;
    logic [11:0] hd_addr;
    logic [15:0] ni_addr;
    logic [16:0] w_addr;
    logic hd_done, ni_done, w_done, busy, err;
    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    logic hs_q = 1'b0;
    int mon_bad = 0, dup = 0, wcount = 0;
    logic [16:0] last_addr = '0;
    bit seen [22928];
    logic quiet_en = 1'b0;
    int quiet_bad = 0;

    gat_bram_loader #(.H_DATA_DEPTH(1000)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .load_clr(load_clr),
        .h_data_bram_din(hd_din), .h_data_bram_ena(hd_ena), .h_data_bram_wea(hd_wea), .h_data_bram_addra(hd_addr),
        .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena), .h_node_info_bram_wea(ni_wea),
        .h_node_info_bram_addra(ni_addr),
        .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
        .h_data_bram_load_done(hd_done), .h_node_info_bram_load_done(ni_done), .wgt_bram_load_done(w_done),
        .loader_busy(busy), .loader_err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hs_q <= mon_en && s_valid && s_ready;

    // Weight-frame monitor: a write must follow each payload handshake by one cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (w_ena !== hs_q || w_wea !== hs_q || hd_ena !== 1'b0 || ni_ena !== 1'b0) mon_bad <= mon_bad + 1;
            if (w_ena === 1'b1) begin
                if (w_addr[16:2] >= 15'd22928 || w_din !== (32'hC0DE0000 | 32'(w_addr[16:2]))) mon_bad <= mon_bad + 1;
                else if (seen[w_addr[16:2]]) dup <= dup + 1;
                else seen[w_addr[16:2]] <= 1'b1;
                wcount <= wcount + 1;
                last_addr <= w_addr;
            end
        end
        if (quiet_en && (hd_ena || ni_ena || w_ena || hd_wea || ni_wea || w_wea)) quiet_bad <= quiet_bad + 1;
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        s_valid = 1'b0;
        load_clr = 1'b0;
        s_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic put(input logic [31:0] d);
        int w = 0;
        s_data = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w == 50) begin
            checks++;
            failures++;
            $display("FAIL put_timeout word=%h s_ready never high", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        s_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags ready=%b busy=%b err=%b want 1 0 0", s_ready, busy, err);
        end
        checks++;
        if ({hd_ena, hd_wea, ni_ena, ni_wea, w_ena, w_wea} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ena got=%b want 000000", {hd_ena, hd_wea, ni_ena, ni_wea, w_ena, w_wea});
        end
        checks++;
        if (hd_din !== 0 || ni_din !== 0 || w_din !== 0 || hd_addr !== 0 || ni_addr !== 0 || w_addr !== 0) begin
            failures++;
            $display("FAIL reset_data din=%h/%h/%h addr=%h/%h/%h want 0", hd_din, ni_din, w_din, hd_addr, ni_addr, w_addr);
        end
        checks++;
        if ({hd_done, ni_done, w_done} !== 3'b0) begin
            failures++;
            $display("FAIL reset_done got=%b want 000", {hd_done, ni_done, w_done});
        end
    endtask

    task automatic test_node_info();
        put({24'd4, 8'd1});
        checks++;
        if (busy !== 1'b1 || ni_ena !== 1'b0) begin
            failures++;
            $display("FAIL ni_header busy=%b ena=%b want 1 0", busy, ni_ena);
        end
        for (int i = 0; i < 4; i++) begin
            put(32'hA0 + 32'(i));
            checks++;
            if (ni_ena !== 1'b1 || ni_wea !== 1'b1 || ni_din !== 32'hA0 + 32'(i) || ni_addr !== 16'(i * 4) ||
                hd_ena !== 1'b0 || w_ena !== 1'b0) begin
                failures++;
                $display("FAIL ni_write%0d ena=%b wea=%b din=%h addr=%h want 1 1 %h %h", i, ni_ena, ni_wea,
                         ni_din, ni_addr, 32'hA0 + 32'(i), i * 4);
            end
        end
        checks++;
        if (s_ready !== 1'b0 || ni_done !== 1'b0) begin
            failures++;
            $display("FAIL ni_done_cycle ready=%b done=%b want 0 0", s_ready, ni_done);
        end
        idle_cycle();
        checks++;
        if (ni_done !== 1'b1 || s_ready !== 1'b1 || ni_ena !== 1'b0 || ni_din !== 32'hA3 || ni_addr !== 16'hC) begin
            failures++;
            $display("FAIL ni_done done=%b ready=%b ena=%b din=%h addr=%h want 1 1 0 a3 c", ni_done, s_ready,
                     ni_ena, ni_din, ni_addr);
        end
    endtask

`ifdef GAT_LOADER_CHECK_EN
    task automatic test_errors();
        reset_dut();
        put({24'd0, 8'd1});
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_n_zero err=%b busy=%b ready=%b want 1 0 1", err, busy, s_ready);
        end
        reset_dut();
        put({24'd1, 8'd3});
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_rsvd err=%b busy=%b want 1 1", err, busy);
        end
        put(32'h12345678);
        checks++;
        if (busy !== 1'b0 || w_ena !== 1'b0) begin
            failures++;
            $display("FAIL rsvd_drain busy=%b wena=%b want 0 0", busy, w_ena);
        end
        idle_cycle();
    endtask

    task automatic test_drain();
        reset_dut();
        put({24'd1001, 8'd0});
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_hdr err=%b busy=%b want 1 1", err, busy);
        end
        quiet_en = 1'b1;
        for (int i = 0; i < 1001; i++) put(32'hDEAD0000 + 32'(i));
        idle_cycle();
        quiet_en = 1'b0;
        checks++;
        if (quiet_bad !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain_quiet writes=%0d busy=%b want 0 0", quiet_bad, busy);
        end
        put({24'd2, 8'd0});
        put(32'h55);
        checks++;
        if (hd_ena !== 1'b1 || hd_din !== 32'h55 || hd_addr !== 12'h0) begin
            failures++;
            $display("FAIL drain_next0 ena=%b din=%h addr=%h want 1 55 0", hd_ena, hd_din, hd_addr);
        end
        put(32'h66);
        checks++;
        if (hd_ena !== 1'b1 || hd_din !== 32'h66 || hd_addr !== 12'h4) begin
            failures++;
            $display("FAIL drain_next1 ena=%b din=%h addr=%h want 1 66 4", hd_ena, hd_din, hd_addr);
        end
        idle_cycle();
        checks++;
        if (hd_done !== 1'b1) begin
            failures++;
            $display("FAIL drain_next_done got=%b want 1", hd_done);
        end
    endtask
`else
    task automatic test_n_zero();
        reset_dut();
        put({24'd0, 8'd2});
        checks++;
        if (w_done !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL nzero_done_cycle done=%b ready=%b want 0 0", w_done, s_ready);
        end
        idle_cycle();
        checks++;
        if (w_done !== 1'b1 || err !== 1'b0 || w_ena !== 1'b0) begin
            failures++;
            $display("FAIL nzero_done done=%b err=%b ena=%b want 1 0 0", w_done, err, w_ena);
        end
    endtask

    task automatic test_rsvd_as_wgt();
        put({24'd1, 8'd3});
        put(32'h33);
        checks++;
        if (w_ena !== 1'b1 || w_din !== 32'h33 || w_addr !== 17'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rsvd_wgt ena=%b din=%h addr=%h err=%b want 1 33 0 0", w_ena, w_din, w_addr, err);
        end
        idle_cycle();
    endtask
`endif

    task automatic test_clr();
        put({24'd1, 8'd0});
        put(32'h11);
        load_clr = 1'b1;
        idle_cycle();
        checks++;
        if (hd_done !== 1'b1) begin
            failures++;
            $display("FAIL clr_set_wins got=%b want 1", hd_done);
        end
        @(posedge clk);
        #1 load_clr = 1'b0;
        checks++;
        if (hd_done !== 1'b0) begin
            failures++;
            $display("FAIL clr_clears got=%b want 0", hd_done);
        end
    endtask

    task automatic test_weight();
        put({24'd22928, 8'd2});
        mon_en = 1'b1;
        for (int i = 0; i < 22928; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            put(32'hC0DE0000 | 32'(i));
        end
        idle_cycle();
        mon_en = 1'b0;
        checks++;
        if (mon_bad !== 0 || dup !== 0) begin
            failures++;
            $display("FAIL wgt_writes bad=%0d dup=%0d want 0 0", mon_bad, dup);
        end
        checks++;
        if (wcount !== 22928) begin
            failures++;
            $display("FAIL wgt_count got=%0d want 22928", wcount);
        end
        checks++;
        if (last_addr !== 17'h1663C || w_addr !== 17'h1663C) begin
            failures++;
            $display("FAIL wgt_last_addr got=%h/%h want 1663c", last_addr, w_addr);
        end
        checks++;
        if (w_done !== 1'b1) begin
            failures++;
            $display("FAIL wgt_done got=%b want 1", w_done);
        end
    endtask

    task automatic test_reset_mid();
        put({24'd8, 8'd0});
        for (int i = 0; i < 3; i++) put(32'hB0 + 32'(i));
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++;
        if ({hd_ena, hd_wea, ni_ena, w_ena, hd_done, ni_done, w_done, busy, err} !== 9'b0 ||
            hd_din !== 0 || hd_addr !== 0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_clear flags=%b din=%h addr=%h ready=%b want 0 0 0 1",
                     {hd_ena, hd_wea, ni_ena, w_ena, hd_done, ni_done, w_done, busy, err}, hd_din, hd_addr, s_ready);
        end
        put({24'd1, 8'd1});
        checks++;
        if (hd_ena !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_header hd_ena=%b busy=%b want 0 1", hd_ena, busy);
        end
        put(32'h77);
        checks++;
        if (ni_ena !== 1'b1 || ni_din !== 32'h77 || ni_addr !== 16'h0) begin
            failures++;
            $display("FAIL midrst_write ena=%b din=%h addr=%h want 1 77 0", ni_ena, ni_din, ni_addr);
        end
        idle_cycle();
        checks++;
        if (ni_done !== 1'b1 || hd_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_done ni=%b hd=%b want 1 0", ni_done, hd_done);
        end
    endtask

    initial begin
        test_reset();
        test_node_info();
`ifdef GAT_LOADER_CHECK_EN
        test_errors();
        test_drain();
`else
        test_n_zero();
        test_rsvd_as_wgt();
`endif
        test_clr();
        test_weight();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
